pipe_if_ctrl: RTL and testbench
===============================

PIPE_IF_CTRL -- requirements
Module: pipe_if_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the maximum number of consecutive imem_ready-low cycles before a fetch-timeout exception is raised.
REQ-002 SHALL have parameter IRQ_MASK_CYC, default 2, the number of cycles interrupts stay masked after a trap redirect.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ex_branch  in  1  conditional branch resident in EX.
REQ-006 ALUOut  in  1  branch-taken flag from the EX ALU.
REQ-007 id_jump  in  1  J/JAL decoded in ID.
REQ-008 id_jr  in  1  JR/JALR decoded in ID.
REQ-009 id_undef  in  1  undefined opcode decoded in ID.
REQ-010 id_rs, id_rt  in  5 each  ID source register numbers.
REQ-011 ex_memread  in  1  load resident in EX.
REQ-012 ex_rt  in  5  load destination register number.
REQ-013 irq  in  1  external interrupt request, level-sensitive.
REQ-014 pc_kernel  in  1  PC[31], the supervisor bit of the current fetch PC.
REQ-015 imem_ready  in  1  instruction memory has delivered the fetch word.
REQ-016 PCSrc  out  3  next-PC select: 000 PC+4, 001 ConBA, 010 JT, 011 DatabusA, 100 IRQ vector, 101 exception vector.
REQ-017 PCWrite  out  1  PC register write enable.
REQ-018 Stall  out  1  hold the IF/ID register.
REQ-019 enable  out  1  instruction memory read enable.
REQ-020 flush_ifid, flush_idex  out  1 each  bubble insertion into IF/ID and ID/EX.
REQ-021 state  out  2  current FSM state, for debug.

Function
REQ-022 SHALL implement the FSM states RUN=0, LU_STALL=1, IMEM_WAIT=2, and TRAP=3.
REQ-023 SHALL resolve events in each cycle with fixed priority: exception (id_undef or timeout) > irq > taken branch > id_jr > id_jump > load-use > imem wait.
REQ-024 SHALL treat irq as accepted only when irq=1, pc_kernel=0, and the mask counter is 0; irq SHALL be ignored when pc_kernel=1.
REQ-025 SHALL detect load-use when ex_memread=1, ex_rt!=0, and ex_rt equals id_rs or id_rt.
REQ-026 RUN, no event: PCSrc=000, PCWrite=1, Stall=0, enable=1, no flushes.
REQ-027 Taken branch (ex_branch and ALUOut): PCSrc=001, PCWrite=1, flush_ifid=1, flush_idex=1, in the same cycle.
REQ-028 id_jr: PCSrc=011, PCWrite=1, flush_ifid=1; id_jump: PCSrc=010, PCWrite=1, flush_ifid=1.
REQ-029 Load-use: PCWrite=0, Stall=1, flush_idex=1, and the next state is LU_STALL.
REQ-030 LU_STALL SHALL last exactly one cycle with outputs as in RUN and then return to RUN, giving a load-use penalty of 1 cycle.
REQ-031 RUN with imem_ready=0: PCWrite=0, Stall=1, enable=1, and the next state is IMEM_WAIT with the wait counter set to 1.
REQ-032 IMEM_WAIT SHALL hold PCWrite=0 and Stall=1 while incrementing the wait counter, and return to RUN on imem_ready=1.
REQ-033 When the wait counter reaches MAX_WAIT, SHALL raise a fetch-timeout exception.
REQ-034 Exception or accepted irq: PCSrc=101 or 100 respectively, PCWrite=1, flush_ifid=1, flush_idex=1, next state TRAP, and the mask counter loaded with IRQ_MASK_CYC.
REQ-035 TRAP SHALL last one cycle with PCWrite=1 and flush_ifid=1 (discarding the wrong-path fetch), then return to RUN.
REQ-036 The mask counter SHALL decrement each cycle until it reaches 0 and SHALL saturate at 0.
REQ-037 A branch, jump, or irq arriving during LU_STALL or IMEM_WAIT SHALL be taken in place of the stall, per the priority in REQ-023, and SHALL clear the wait counter.
REQ-038 An irq arriving in TRAP SHALL be deferred by the mask.
REQ-039 The wait counter SHALL be $clog2(MAX_WAIT+1) bits and SHALL never wrap.

Reset
REQ-040 While reset=0: state=RUN, both counters 0, PCSrc=000, PCWrite=0, Stall=0, enable=0, flushes 0.
REQ-041 Reset assertion SHALL take effect immediately, including during IMEM_WAIT or TRAP.
REQ-042 Following reset deassertion, SHALL resume RUN outputs on the first clock edge.

Structure
REQ-043 Package pipe_ctrl_pkg SHALL hold the PCSrc encodings, the state encodings, and the vector constants (IRQ 32'h80000004, exception 32'h80000008).
REQ-044 Load-use comparison SHALL be a combinational sub-module, pipe_hazard_detect.
REQ-045 The FSM, the counters, and the priority mux SHALL be in pipe_if_ctrl.

Verification
REQ-046 Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> one cycle PCWrite=0, Stall=1, flush_idex=1; next cycle state=1; then RUN.
REQ-047 Branch with load-use in the same cycle: ex_branch=1, ALUOut=1 -> PCSrc=001, both flushes, no stall.
REQ-048 Imem wait: imem_ready=0 for 3 cycles -> PCWrite=0 for 3 cycles, state=2, then RUN on ready; with MAX_WAIT=4 and ready held low 4 cycles -> PCSrc=101, state=3.
REQ-049 IRQ: irq=1, pc_kernel=0 -> PCSrc=100, state=3; irq held -> no retrigger for 2 cycles; pc_kernel=1 -> irq ignored.
REQ-050 Exception vs irq: id_undef=1 and irq=1 together -> PCSrc=101.
REQ-051 Reset in IMEM_WAIT: reset=0 mid-wait -> outputs go to reset values asynchronously; counters read 0 after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the IF-stage pipeline controller: states, next-PC selects,
// trap vectors and the bundle of control outputs driven each cycle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_TRAP      = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    PC_PLUS4    = 3'b000,
    PC_CONBA    = 3'b001,
    PC_JT       = 3'b010,
    PC_DATABUSA = 3'b011,
    PC_IRQ      = 3'b100,
    PC_EXC      = 3'b101
  } pcsrc_e;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  typedef struct packed {
    pcsrc_e pc_src;
    logic   pc_write;
    logic   stall;
    logic   enable;
    logic   flush_ifid;
    logic   flush_idex;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_src: PC_PLUS4, pc_write: 1'b1, stall: 1'b0,
                                 enable: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b0};
  localparam ctrl_t CTRL_OFF = '{pc_src: PC_PLUS4, pc_write: 1'b0, stall: 1'b0,
                                 enable: 1'b0, flush_ifid: 1'b0, flush_idex: 1'b0};

  // Any PC redirect discards the fetched word; EX is flushed only when the
  // instruction sitting in ID/EX is also on the wrong path.
  function automatic ctrl_t redirect(input pcsrc_e src, input logic kill_idex);
    ctrl_t c;
    c            = CTRL_RUN;
    c.pc_src     = src;
    c.flush_ifid = 1'b1;
    c.flush_idex = kill_idex;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds either ID source.
module pipe_hazard_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_if_ctrl.sv
// IF-stage controller: prioritised next-PC select, stall/flush generation,
// fetch-timeout watchdog and post-trap interrupt masking.
module pipe_if_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT     = 15,
  parameter int IRQ_MASK_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_branch,
  input  logic       ALUOut,
  input  logic       id_jump,
  input  logic       id_jr,
  input  logic       id_undef,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       irq,
  input  logic       pc_kernel,
  input  logic       imem_ready,
  output logic [2:0] PCSrc,
  output logic       PCWrite,
  output logic       Stall,
  output logic       enable,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic [1:0] state
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int MB = (IRQ_MASK_CYC > 0) ? $clog2(IRQ_MASK_CYC + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [MB-1:0] MASK_LOAD  = MB'(IRQ_MASK_CYC);

  state_e        st, st_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [MB-1:0] mask_cnt, mask_nxt;
  logic          load_use, timeout, irq_ok, trap;
  ctrl_t         ctrl;

  pipe_hazard_detect u_hazard (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  assign timeout = (st == ST_IMEM_WAIT) && (wait_cnt == WAIT_LIMIT);
  assign irq_ok  = irq && !pc_kernel && (mask_cnt == '0);

  always_comb begin
    ctrl     = CTRL_RUN;
    st_nxt   = ST_RUN;
    wait_nxt = '0;
    trap     = 1'b0;
    if (st == ST_TRAP) begin
      // Vector fetch is in flight; the word already in IF/ID is wrong-path.
      ctrl.flush_ifid = 1'b1;
    end else if (id_undef || timeout) begin
      ctrl = redirect(PC_EXC, 1'b1);
      trap = 1'b1;
    end else if (irq_ok) begin
      ctrl = redirect(PC_IRQ, 1'b1);
      trap = 1'b1;
    end else if (ex_branch && ALUOut) begin
      ctrl = redirect(PC_CONBA, 1'b1);
    end else if (id_jr) begin
      ctrl = redirect(PC_DATABUSA, 1'b0);
    end else if (id_jump) begin
      ctrl = redirect(PC_JT, 1'b0);
    end else if (st != ST_LU_STALL && load_use) begin
      ctrl.pc_write   = 1'b0;
      ctrl.stall      = 1'b1;
      ctrl.flush_idex = 1'b1;
      st_nxt          = ST_LU_STALL;
    end else if (st != ST_LU_STALL && !imem_ready) begin
      ctrl.pc_write = 1'b0;
      ctrl.stall    = 1'b1;
      st_nxt        = ST_IMEM_WAIT;
      // Timeout is checked first, so the increment stays below WAIT_LIMIT+1.
      wait_nxt      = (st == ST_IMEM_WAIT) ? wait_cnt + WW'(1) : WW'(1);
    end
    if (trap) st_nxt = ST_TRAP;
    mask_nxt = trap ? MASK_LOAD : ((mask_cnt != '0) ? mask_cnt - MB'(1) : '0);
    if (!reset) ctrl = CTRL_OFF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= ST_RUN;
      wait_cnt <= '0;
      mask_cnt <= '0;
    end else begin
      st       <= st_nxt;
      wait_cnt <= wait_nxt;
      mask_cnt <= mask_nxt;
    end
  end

  assign PCSrc      = ctrl.pc_src;
  assign PCWrite    = ctrl.pc_write;
  assign Stall      = ctrl.stall;
  assign enable     = ctrl.enable;
  assign flush_ifid = ctrl.flush_ifid;
  assign flush_idex = ctrl.flush_idex;
  assign state      = st;

endmodule

// File: tb/tb_pipe_if_ctrl.sv
// Self-checking bench for pipe_if_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_if_ctrl;

  localparam int MW   = 4;
  localparam int MASK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_branch, ALUOut, id_jump, id_jr, id_undef;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, irq, pc_kernel, imem_ready;
  logic [2:0] PCSrc;
  logic       PCWrite, Stall, enable, flush_ifid, flush_idex;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: how many fetch-wait cycles have elapsed, whether we are in the
  // cycle after a load-use stall or a trap redirect, and mask cycles remaining.
  int m_low, m_mask;
  bit m_trap, m_lu;

  pipe_if_ctrl #(.MAX_WAIT(MW), .IRQ_MASK_CYC(MASK)) dut (
    .clk(clk), .reset(reset), .ex_branch(ex_branch), .ALUOut(ALUOut),
    .id_jump(id_jump), .id_jr(id_jr), .id_undef(id_undef), .id_rs(id_rs),
    .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt), .irq(irq),
    .pc_kernel(pc_kernel), .imem_ready(imem_ready), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .Stall(Stall), .enable(enable), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .state(state)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ex_branch = 0; ALUOut = 0; id_jump = 0; id_jr = 0; id_undef = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_memread = 0; irq = 0; pc_kernel = 0;
    imem_ready = 1;
  endtask

  task automatic model_reset();
    m_low = 0; m_mask = 0; m_trap = 0; m_lu = 0;
  endtask

  // Expected {PCSrc,PCWrite,Stall,enable,flush_ifid,flush_idex,state} for the
  // inputs now applied, then advance the model one clock.
  task automatic model_step(output logic [9:0] e);
    logic [2:0] pc; logic pw, stl, fi, fd; logic [1:0] s;
    bit lu, irq_ok, tk, lu_tk; int nlow;
    s  = m_trap ? 2'd3 : m_lu ? 2'd1 : (m_low > 0) ? 2'd2 : 2'd0;
    pc = 3'd0; pw = 1; stl = 0; fi = 0; fd = 0; tk = 0; lu_tk = 0; nlow = 0;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    irq_ok = irq && !pc_kernel && m_mask == 0;
    if (m_trap) fi = 1;
    else if (id_undef || m_low >= MW) begin pc = 3'd5; fi = 1; fd = 1; tk = 1; end
    else if (irq_ok) begin pc = 3'd4; fi = 1; fd = 1; tk = 1; end
    else if (ex_branch && ALUOut) begin pc = 3'd1; fi = 1; fd = 1; end
    else if (id_jr) begin pc = 3'd3; fi = 1; end
    else if (id_jump) begin pc = 3'd2; fi = 1; end
    else if (!m_lu && lu) begin pw = 0; stl = 1; fd = 1; lu_tk = 1; end
    else if (!m_lu && !imem_ready) begin pw = 0; stl = 1; nlow = m_low + 1; end
    e = {pc, pw, stl, 1'b1, fi, fd, s};
    m_trap = tk; m_lu = lu_tk; m_low = nlow;
    m_mask = tk ? MASK : (m_mask > 0 ? m_mask - 1 : 0);
  endtask

  task automatic tick(output logic [9:0] o, output logic [9:0] e);
    #1;
    o = {PCSrc, PCWrite, Stall, enable, flush_ifid, flush_idex, state};
    model_step(e);
    @(negedge clk);
  endtask

  function automatic logic [9:0] outs();
    return {PCSrc, PCWrite, Stall, enable, flush_ifid, flush_idex, state};
  endfunction

  task automatic test_reset();
    logic [9:0] o, e;
    reset = 0; idle(); model_reset();
    imem_ready = 0; irq = 1; ex_branch = 1; ALUOut = 1;
    #2; o = outs(); n_cmp++;
    if (o !== 10'b0) begin n_bad++; $display("FAIL reset_hold: got %b want %b", o, 10'b0); end
    repeat (2) @(posedge clk);
    #1; o = outs(); n_cmp++;
    if (o !== 10'b0) begin n_bad++; $display("FAIL reset_clocked: got %b want %b", o, 10'b0); end
    @(negedge clk); idle(); reset = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b0001010000) begin n_bad++; $display("FAIL reset_release: got %b want %b", o, 10'b0001010000); end
  endtask

  task automatic test_load_use();
    logic [9:0] o, e;
    logic [9:0] want [3] = '{10'b0000110100, 10'b0001010001, 10'b0001010000};
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) begin ex_memread = 1; ex_rt = 5; id_rs = 5; end
      tick(o, e); n_cmp++;
      if (o !== want[i]) begin n_bad++; $display("FAIL load_use[%0d]: got %b want %b", i, o, want[i]); end
    end
  endtask

  task automatic test_branch_lu();
    logic [9:0] o, e;
    idle(); ex_memread = 1; ex_rt = 5; id_rt = 5; ex_branch = 1; ALUOut = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b0011011100) begin n_bad++; $display("FAIL branch_over_lu: got %b want %b", o, 10'b0011011100); end
    idle(); id_jr = 1; id_jump = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b0111011000) begin n_bad++; $display("FAIL jr_over_jump: got %b want %b", o, 10'b0111011000); end
    idle(); id_jump = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b0101011000) begin n_bad++; $display("FAIL jump: got %b want %b", o, 10'b0101011000); end
  endtask

  task automatic test_imem_wait();
    logic [9:0] o, e;
    logic [9:0] w1 [5] = '{10'b0000110000, 10'b0000110010, 10'b0000110010,
                           10'b0001010010, 10'b0001010000};
    logic [9:0] w2 [6] = '{10'b0000110000, 10'b0000110010, 10'b0000110010,
                           10'b0000110010, 10'b1011011110, 10'b0001011011};
    for (int i = 0; i < 5; i++) begin
      idle(); imem_ready = (i >= 3);
      tick(o, e); n_cmp++;
      if (o !== w1[i]) begin n_bad++; $display("FAIL imem_wait[%0d]: got %b want %b", i, o, w1[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      idle(); imem_ready = 0;
      tick(o, e); n_cmp++;
      if (o !== w2[i]) begin n_bad++; $display("FAIL imem_timeout[%0d]: got %b want %b", i, o, w2[i]); end
    end
    idle(); tick(o, e); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL post_timeout: got %b want %b", o, e); end
  endtask

  task automatic test_irq();
    logic [9:0] o, e;
    logic [9:0] want [7] = '{10'b1001011100, 10'b0001011011, 10'b0001010000,
                             10'b1001011100, 10'b0001011011, 10'b0001010000,
                             10'b0001010000};
    for (int i = 0; i < 7; i++) begin
      idle();
      irq = (i < 4) || (i == 6);
      pc_kernel = (i == 6);
      tick(o, e); n_cmp++;
      if (o !== want[i]) begin n_bad++; $display("FAIL irq[%0d]: got %b want %b", i, o, want[i]); end
    end
  endtask

  task automatic test_exc_vs_irq();
    logic [9:0] o, e;
    idle(); id_undef = 1; irq = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b1011011100) begin n_bad++; $display("FAIL exc_over_irq: got %b want %b", o, 10'b1011011100); end
    idle(); id_undef = 1; irq = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b0001011011) begin n_bad++; $display("FAIL trap_ignores: got %b want %b", o, 10'b0001011011); end
    idle(); tick(o, e); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL post_exc: got %b want %b", o, e); end
  endtask

  task automatic test_reset_mid_wait();
    logic [9:0] o, e;
    idle(); imem_ready = 0;
    tick(o, e); tick(o, e); n_cmp++;
    if (o !== 10'b0000110010) begin n_bad++; $display("FAIL pre_reset_wait: got %b want %b", o, 10'b0000110010); end
    #2 reset = 0;
    #1 o = outs(); n_cmp++;
    if (o !== 10'b0) begin n_bad++; $display("FAIL async_reset_wait: got %b want %b", o, 10'b0); end
    @(negedge clk); reset = 1; model_reset();
    for (int i = 0; i < MW + 3; i++) begin
      idle(); imem_ready = (i >= MW + 1);
      tick(o, e); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wait_after_reset[%0d]: got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_reset_in_trap();
    logic [9:0] o, e;
    idle(); tick(o, e); tick(o, e);
    idle(); irq = 1;
    tick(o, e); n_cmp++;
    if (o !== 10'b1001011100) begin n_bad++; $display("FAIL irq_before_reset: got %b want %b", o, 10'b1001011100); end
    #2 reset = 0;
    #1 o = outs(); n_cmp++;
    if (o !== 10'b0) begin n_bad++; $display("FAIL async_reset_trap: got %b want %b", o, 10'b0); end
    @(negedge clk); reset = 1; model_reset();
    tick(o, e); n_cmp++;
    if (o !== 10'b1001011100) begin n_bad++; $display("FAIL mask_cleared: got %b want %b", o, 10'b1001011100); end
    for (int i = 0; i < 3; i++) begin
      idle(); tick(o, e); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL after_trap_reset[%0d]: got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_random();
    logic [9:0] o, e;
    for (int i = 0; i < 800; i++) begin
      id_undef   = ($urandom_range(0, 99) < 3);
      irq        = ($urandom_range(0, 99) < 12);
      pc_kernel  = ($urandom_range(0, 99) < 30);
      ex_branch  = ($urandom_range(0, 99) < 15);
      ALUOut     = ($urandom_range(0, 99) < 50);
      id_jr      = ($urandom_range(0, 99) < 5);
      id_jump    = ($urandom_range(0, 99) < 5);
      ex_memread = ($urandom_range(0, 99) < 35);
      ex_rt      = 5'($urandom_range(0, 3));
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      imem_ready = ($urandom_range(0, 99) >= 40);
      tick(o, e); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL random[%0d]: got %b want %b", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_imem_wait();
    test_irq();
    test_exc_vs_irq();
    test_reset_mid_wait();
    test_reset_in_trap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
